// File: rtl/mrr_tagged_loopback_queue.sv
// Tagged loopback queue: pushes are stored with an age stamp, and each pop returns the oldest message for one chip ID.
// Push acks 2 cycles after request; pop acks DEPTH+2/DEPTH+3 cycles after request; level requests are held until the ack, and a push write waits while a pop scans.
module mrr_tagged_loopback_queue #(
    parameter int NUM_POP_PORTS    = 4,
    parameter int CHIP_ID_LEN      = 8,
    parameter int MSG_LEN          = 32,
    parameter int DEPTH_LOG2       = 4,
    parameter int SEQ_LEN          = 16,
    parameter int OVERWRITE_OLDEST = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_POP_PORTS*CHIP_ID_LEN-1:0] pop_chip_id,
    input  logic [NUM_POP_PORTS-1:0]             pop_request,
    output logic [NUM_POP_PORTS-1:0]             pop_ack,
    output logic                                 pop_valid,
    output logic [MSG_LEN-1:0]                   pop_message,
    input  logic [CHIP_ID_LEN-1:0]               push_chip_id,
    input  logic [MSG_LEN-1:0]                   push_message,
    input  logic                                 push_request,
    output logic                                 push_ack,
    output logic                                 push_drop,
    output logic [DEPTH_LOG2:0]                  occupancy,
    output logic                                 full,
    output logic                                 empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (NUM_POP_PORTS > 1) ? $clog2(NUM_POP_PORTS) : 1;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef struct packed {
        logic                   vld;
        logic [SEQ_LEN-1:0]     seq;
        logic [CHIP_ID_LEN-1:0] id;
        logic [MSG_LEN-1:0]     msg;
    } entry_t;

    typedef enum logic [1:0] {P_IDLE, P_SCAN, P_WRITE, P_ACK} push_state_t;
    typedef enum logic [1:0] {Q_IDLE, Q_SCAN, Q_INVAL, Q_ACK} pop_state_t;

    entry_t                  ent [DEPTH];
    logic [SEQ_LEN-1:0]      push_seq;
    push_state_t             push_state;
    pop_state_t              pop_state;

    logic [CHIP_ID_LEN-1:0]  lat_id;
    logic [MSG_LEN-1:0]      lat_msg;
    logic [DEPTH_LOG2-1:0]   ps_idx;
    logic [DEPTH_LOG2-1:0]   ps_best;
    logic                    ps_found;

    logic [PW-1:0]           q_chain;
    logic [CHIP_ID_LEN-1:0]  q_id;
    logic [DEPTH_LOG2-1:0]   q_idx;
    logic [DEPTH_LOG2-1:0]   q_best;
    logic                    q_found;
    logic                    q_hit;
    logic [MSG_LEN-1:0]      q_msg;

    // Modular distance from the current stamp keeps ordering valid across push_seq wrap
    function automatic logic [SEQ_LEN-1:0] age_of(input logic [SEQ_LEN-1:0] now,
                                                  input logic [SEQ_LEN-1:0] stamp);
        return now - stamp;
    endfunction

    logic [DEPTH_LOG2-1:0] free_idx;
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].vld) free_idx = DEPTH_LOG2'(i);
        end
    end

    // The chain being acked this cycle still holds its request, so it is masked out
    logic [NUM_POP_PORTS-1:0] req_eff;
    logic [PW-1:0]            sel_chain;
    logic [CHIP_ID_LEN-1:0]   sel_id;
    assign req_eff = pop_request & ~pop_ack;
    always_comb begin
        sel_chain = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_POP_PORTS; i++) begin
            if (req_eff[i]) begin
                sel_chain = PW'(i);
                sel_id    = pop_chip_id[i*CHIP_ID_LEN +: CHIP_ID_LEN];
            end
        end
    end

    logic ps_take, q_take, pop_busy, wr_en, inv_en;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign ps_take  = ent[ps_idx].vld &&
                      (!ps_found || age_of(push_seq, ent[ps_idx].seq) > age_of(push_seq, ent[ps_best].seq));
    assign q_take   = ent[q_idx].vld && (ent[q_idx].id == q_id) &&
                      (!q_found || age_of(push_seq, ent[q_idx].seq) > age_of(push_seq, ent[q_best].seq));
    assign pop_busy = (pop_state == Q_SCAN) || (pop_state == Q_INVAL);
    assign wr_en    = (push_state == P_WRITE) && !pop_busy;
    assign inv_en   = (pop_state == Q_INVAL);
    assign wr_idx   = ps_found ? ps_best : free_idx;
    assign full     = (occupancy == OCC_FULL);
    assign empty    = (occupancy == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            push_seq  <= '0;
            occupancy <= '0;
        end else if (wr_en) begin
            ent[wr_idx] <= '{vld: 1'b1, seq: push_seq, id: lat_id, msg: lat_msg};
            push_seq    <= push_seq + SEQ_LEN'(1);
            if (!ent[wr_idx].vld) occupancy <= occupancy + OCC_ONE;
        end else if (inv_en) begin
            ent[q_best].vld <= 1'b0;
            occupancy       <= occupancy - OCC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_state <= P_IDLE;
            push_ack   <= 1'b0;
            push_drop  <= 1'b0;
            lat_id     <= '0;
            lat_msg    <= '0;
            ps_idx     <= '0;
            ps_best    <= '0;
            ps_found   <= 1'b0;
        end else begin
            push_ack <= 1'b0;
            case (push_state)
                P_IDLE: begin
                    if (push_request) begin
                        lat_id   <= push_chip_id;
                        lat_msg  <= push_message;
                        ps_idx   <= '0;
                        ps_found <= 1'b0;
                        if (!full) begin
                            push_state <= P_WRITE;
                        end else if (OVERWRITE_OLDEST == 0) begin
                            push_state <= P_ACK;
                            push_ack   <= 1'b1;
                            push_drop  <= 1'b1;
                        end else begin
                            push_state <= P_SCAN;
                        end
                    end
                end
                P_SCAN: begin
                    if (ps_take) begin
                        ps_best  <= ps_idx;
                        ps_found <= 1'b1;
                    end
                    ps_idx <= ps_idx + DEPTH_LOG2'(1);
                    if (ps_idx == LAST_IDX) push_state <= P_WRITE;
                end
                P_WRITE: begin
                    if (!pop_busy) begin
                        push_state <= P_ACK;
                        push_ack   <= 1'b1;
                        push_drop  <= 1'b0;
                    end
                end
                P_ACK: begin
                    if (!push_request) push_state <= P_IDLE;
                end
                default: push_state <= P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_state   <= Q_IDLE;
            pop_ack     <= '0;
            pop_valid   <= 1'b0;
            pop_message <= '0;
            q_chain     <= '0;
            q_id        <= '0;
            q_idx       <= '0;
            q_best      <= '0;
            q_found     <= 1'b0;
            q_hit       <= 1'b0;
            q_msg       <= '0;
        end else begin
            pop_ack <= '0;
            case (pop_state)
                Q_IDLE: begin
                    if (|req_eff) begin
                        q_chain   <= sel_chain;
                        q_id      <= sel_id;
                        q_idx     <= '0;
                        q_found   <= 1'b0;
                        pop_state <= Q_SCAN;
                    end
                end
                Q_SCAN: begin
                    if (q_take) begin
                        q_best  <= q_idx;
                        q_found <= 1'b1;
                    end
                    q_idx <= q_idx + DEPTH_LOG2'(1);
                    if (q_idx == LAST_IDX) begin
                        if (q_found || q_take) begin
                            pop_state <= Q_INVAL;
                        end else begin
                            q_hit     <= 1'b0;
                            q_msg     <= '0;
                            pop_state <= Q_ACK;
                        end
                    end
                end
                Q_INVAL: begin
                    q_hit     <= 1'b1;
                    q_msg     <= ent[q_best].msg;
                    pop_state <= Q_ACK;
                end
                Q_ACK: begin
                    pop_ack     <= NUM_POP_PORTS'(1) << q_chain;
                    pop_valid   <= q_hit;
                    pop_message <= q_msg;
                    pop_state   <= Q_IDLE;
                end
                default: pop_state <= Q_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mrr_tagged_loopback_queue.sv
// Bench for mrr_tagged_loopback_queue: three instances (drop mode, overwrite mode, 3-bit stamps) against an age-ordered list model.
module tb_mrr_tagged_loopback_queue;

    localparam int NP = 2;
    localparam int CW = 8;
    localparam int MW = 32;
    localparam int DL = 2;
    localparam int DEPTH = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP*CW-1:0] pop_chip_id  [ND];
    logic [NP-1:0]    pop_request  [ND];
    logic [NP-1:0]    pop_ack      [ND];
    logic             pop_valid    [ND];
    logic [MW-1:0]    pop_message  [ND];
    logic [CW-1:0]    push_chip_id [ND];
    logic [MW-1:0]    push_message [ND];
    logic             push_request [ND];
    logic             push_ack     [ND];
    logic             push_drop    [ND];
    logic [DL:0]      occupancy    [ND];
    logic             full         [ND];
    logic             empty        [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mrr_tagged_loopback_queue #(
            .NUM_POP_PORTS(NP), .CHIP_ID_LEN(CW), .MSG_LEN(MW), .DEPTH_LOG2(DL),
            .SEQ_LEN((g == 2) ? 3 : 16), .OVERWRITE_OLDEST((g == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .pop_chip_id(pop_chip_id[g]), .pop_request(pop_request[g]), .pop_ack(pop_ack[g]),
            .pop_valid(pop_valid[g]), .pop_message(pop_message[g]),
            .push_chip_id(push_chip_id[g]), .push_message(push_message[g]),
            .push_request(push_request[g]), .push_ack(push_ack[g]), .push_drop(push_drop[g]),
            .occupancy(occupancy[g]), .full(full[g]), .empty(empty[g])
        );
    end

    int tests = 0;
    int errors = 0;
    logic [ND-1:0] busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: stored messages per instance, oldest first
    typedef struct packed {
        logic [CW-1:0] id;
        logic [MW-1:0] msg;
    } ment_t;
    ment_t mq [ND][DEPTH];
    int    mcnt [ND];

    task automatic m_push(input int d, input logic [CW-1:0] id, input logic [MW-1:0] msg, output logic drop);
        drop = 1'b0;
        if (mcnt[d] < DEPTH) begin
            mq[d][mcnt[d]] = {id, msg};
            mcnt[d]++;
        end else if (d == 1) begin
            for (int k = 0; k < DEPTH - 1; k++) mq[d][k] = mq[d][k+1];
            mq[d][DEPTH-1] = {id, msg};
        end else begin
            drop = 1'b1;
        end
    endtask

    task automatic m_pop(input int d, input logic [CW-1:0] id, output logic hit, output logic [MW-1:0] msg);
        int pos;
        hit = 1'b0;
        msg = '0;
        pos = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && k < mcnt[d] && mq[d][k].id == id) begin
                hit = 1'b1;
                msg = mq[d][k].msg;
                pos = k;
            end
        end
        if (hit) begin
            for (int k = pos; k < DEPTH - 1; k++) mq[d][k] = mq[d][k+1];
            mcnt[d]--;
        end
    endtask

    task automatic m_clear();
        for (int d = 0; d < ND; d++) mcnt[d] = 0;
    endtask

    // Per-cycle comparison of idle instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                if (!busy[d]) begin
                    chk("idle_occupancy", 64'(occupancy[d]), 64'(mcnt[d]));
                    chk("idle_full", 64'(full[d]), 64'(mcnt[d] == DEPTH));
                    chk("idle_empty", 64'(empty[d]), 64'(mcnt[d] == 0));
                    chk("idle_pop_ack", 64'(pop_ack[d]), 64'd0);
                    chk("idle_push_ack", 64'(push_ack[d]), 64'd0);
                end
            end
        end
    end

    task automatic chk_reset(input int d);
        chk("rst_pop_ack", 64'(pop_ack[d]), 64'd0);
        chk("rst_pop_valid", 64'(pop_valid[d]), 64'd0);
        chk("rst_pop_message", 64'(pop_message[d]), 64'd0);
        chk("rst_push_ack", 64'(push_ack[d]), 64'd0);
        chk("rst_push_drop", 64'(push_drop[d]), 64'd0);
        chk("rst_occupancy", 64'(occupancy[d]), 64'd0);
        chk("rst_full", 64'(full[d]), 64'd0);
        chk("rst_empty", 64'(empty[d]), 64'd1);
    endtask

    // Waits for the pop ack of one chain; exp_lat 0 = derive from hit/miss, -1 = don't check latency
    task automatic wait_pop(input int d, input int ch, input logic [CW-1:0] id, input int exp_lat);
        logic hit;
        logic [MW-1:0] msg;
        int lat;
        logic got;
        m_pop(d, id, hit, msg);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            if (pop_ack[d] != '0) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("pop_ack_seen", 64'(got), 64'd1);
        chk("pop_ack_chain", 64'(pop_ack[d]), 64'd1 << ch);
        chk("pop_valid", 64'(pop_valid[d]), 64'(hit));
        chk("pop_message", 64'(pop_message[d]), 64'(msg));
        chk("pop_occupancy", 64'(occupancy[d]), 64'(mcnt[d]));
        if (exp_lat == 0) chk("pop_latency", 64'(lat), hit ? 64'(DEPTH + 3) : 64'(DEPTH + 2));
        else if (exp_lat > 0) chk("pop_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic do_pop(input int d, input int ch, input logic [CW-1:0] id);
        busy[d] = 1'b1;
        pop_chip_id[d][ch*CW +: CW] = id;
        pop_request[d][ch] = 1'b1;
        wait_pop(d, ch, id, 0);
        pop_request[d][ch] = 1'b0;
        @(posedge clk); #1;
        chk("pop_ack_pulse", 64'(pop_ack[d]), 64'd0);
        busy[d] = 1'b0;
    endtask

    task automatic do_push(input int d, input logic [CW-1:0] id, input logic [MW-1:0] msg);
        logic drop, was_full, got;
        int lat;
        was_full = (mcnt[d] == DEPTH);
        m_push(d, id, msg, drop);
        busy[d] = 1'b1;
        push_chip_id[d] = id;
        push_message[d] = msg;
        push_request[d] = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            if (push_ack[d]) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("push_ack_seen", 64'(got), 64'd1);
        chk("push_drop", 64'(push_drop[d]), 64'(drop));
        chk("push_occupancy", 64'(occupancy[d]), 64'(mcnt[d]));
        chk("push_full", 64'(full[d]), 64'(mcnt[d] == DEPTH));
        if (!was_full) chk("push_latency", 64'(lat), 64'd2);
        else if (d != 1) chk("drop_latency", 64'(lat), 64'd1);
        push_request[d] = 1'b0;
        push_chip_id[d] = '0;
        push_message[d] = '0;
        @(posedge clk); #1;
        chk("push_ack_pulse", 64'(push_ack[d]), 64'd0);
        busy[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] rid;
        busy = '1;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            pop_chip_id[d] = '0;
            pop_request[d] = '0;
            push_chip_id[d] = '0;
            push_message[d] = '0;
            push_request[d] = 1'b0;
        end
        m_clear();
        #1;
        for (int d = 0; d < ND; d++) chk_reset(d);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        busy = '0;

        // Basic ordering per chip ID
        do_push(0, 8'd3, 32'hA);
        do_push(0, 8'd5, 32'hB);
        do_push(0, 8'd3, 32'hC);
        chk("lit_occ3", 64'(occupancy[0]), 64'd3);
        do_pop(0, 0, 8'd3);
        chk("lit_msgA", 64'(pop_message[0]), 64'hA);
        chk("lit_occ2", 64'(occupancy[0]), 64'd2);
        do_pop(0, 0, 8'd3);
        chk("lit_msgC", 64'(pop_message[0]), 64'hC);
        chk("lit_occ1", 64'(occupancy[0]), 64'd1);

        // Simultaneous requests: highest chain wins
        do_push(0, 8'd3, 32'hA2);
        busy[0] = 1'b1;
        pop_chip_id[0] = {8'd5, 8'd3};
        pop_request[0] = 2'b11;
        wait_pop(0, 1, 8'd5, 0);
        chk("lit_msgB", 64'(pop_message[0]), 64'hB);
        pop_request[0][1] = 1'b0;
        wait_pop(0, 0, 8'd3, -1);
        chk("lit_msgA2", 64'(pop_message[0]), 64'hA2);
        pop_request[0][0] = 1'b0;
        @(posedge clk); #1;
        chk("pop_ack_pulse", 64'(pop_ack[0]), 64'd0);
        busy[0] = 1'b0;

        // Miss
        do_push(0, 8'd1, 32'h11);
        do_pop(0, 1, 8'd7);
        chk("lit_miss_valid", 64'(pop_valid[0]), 64'd0);
        chk("lit_miss_msg", 64'(pop_message[0]), 64'd0);
        chk("lit_miss_occ", 64'(occupancy[0]), 64'd1);
        do_pop(0, 0, 8'd1);

        // Full queue: drop vs overwrite
        for (int k = 0; k < DEPTH; k++) begin
            do_push(0, 8'(k + 1), 32'h100 + k);
            do_push(1, 8'(k + 1), 32'h200 + k);
        end
        do_push(0, 8'd9, 32'h999);
        chk("lit_drop", 64'(push_drop[0]), 64'd1);
        chk("lit_drop_full", 64'(full[0]), 64'd1);
        chk("lit_drop_occ", 64'(occupancy[0]), 64'd4);
        do_push(1, 8'd1, 32'hF5);
        chk("lit_ow_nodrop", 64'(push_drop[1]), 64'd0);
        chk("lit_ow_occ", 64'(occupancy[1]), 64'd4);
        do_pop(1, 0, 8'd1);
        chk("lit_ow_msg", 64'(pop_message[1]), 64'hF5);
        do_pop(1, 1, 8'd2);
        chk("lit_ow_msg2", 64'(pop_message[1]), 64'h201);

        // Stamp wrap with 3-bit sequence
        do_push(2, 8'd2, 32'd100);
        do_push(2, 8'd2, 32'd101);
        for (int i = 0; i < 20; i++) begin
            do_pop(2, i % 2, 8'd2);
            chk("lit_wrap_order", 64'(pop_message[2]), 64'(100 + i));
            do_push(2, 8'd2, 32'(102 + i));
        end

        // Reset in the middle of a pop scan
        busy[0] = 1'b1;
        pop_chip_id[0][CW-1:0] = 8'd3;
        pop_request[0] = 2'b01;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        m_clear();
        #1;
        for (int d = 0; d < ND; d++) chk_reset(d);
        pop_request[0] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            chk("no_ack_after_rst", 64'(pop_ack[0]), 64'd0);
        end
        busy[0] = 1'b0;

        // Randomized traffic on drop and overwrite instances
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                if ($urandom_range(0, 99) < 50) begin
                    do_push(d, 8'($urandom_range(1, 3)), $urandom);
                end else begin
                    rid = 8'($urandom_range(0, 3));
                    if (rid == 8'd0) rid = 8'd7;
                    do_pop(d, $urandom_range(0, 1), rid);
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
